// File: rtl/opfetch_pkg.sv
// Shared constants and types for the operand fetch stage.
package opfetch_pkg;

    localparam int XLEN_DEFAULT       = 32;
    localparam int REG_ADDR_W_DEFAULT = 5;
    localparam int CTRL_W             = 8;

    // Bit positions inside the packed decode-control word
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_READ  = 1;

    // Source of a resolved operand
    typedef enum logic [1:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_WB,
        FWD_RF
    } fwd_sel_e;

endpackage

// File: rtl/operand_bypass_mux.sv
// Per-source operand resolution: x0 forcing, EX/WB bypass, and RAW hazard flag.
// With OPFETCH_FWD_EN undefined, the bypass is removed and every RAW match
// with EX or WB becomes a hazard instead.
module operand_bypass_mux
    import opfetch_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [XLEN-1:0]       read_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [XLEN-1:0]       ex_result,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_write_valid,
    input  logic [XLEN-1:0]       wb_data,
    output logic [XLEN-1:0]       operand,
    output logic                  hazard
);

    fwd_sel_e sel;
    logic     ex_match;
    logic     wb_match;

    // rs != 0 also excludes ex_rd/wb_rd == 0 since the indices must be equal
    assign ex_match = ex_reg_write   && (rs != '0) && (ex_rd == rs);
    assign wb_match = wb_write_valid && (rs != '0) && (wb_rd == rs);

`ifdef OPFETCH_FWD_EN
    // A load in EX has no data yet; only that case must wait
    assign hazard = ex_match && ex_mem_read;
`else
    // Without bypass any in-flight producer must commit before the read
    assign hazard = ex_match || wb_match;
`endif

    // Select operand source; EX beats WB so the youngest producer wins
    always_comb begin
        sel = FWD_RF;
        if (rs == '0)
            sel = FWD_ZERO;
`ifdef OPFETCH_FWD_EN
        else if (ex_match && !ex_mem_read)
            sel = FWD_EX;
        else if (wb_match)
            sel = FWD_WB;
`endif
    end

    // Operand value for the chosen source
    always_comb begin
        case (sel)
            FWD_ZERO: operand = '0;
            FWD_EX:   operand = ex_result;
            FWD_WB:   operand = wb_data;
            default:  operand = read_data;
        endcase
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID/EX operand stage: drives register file reads, resolves operands through
// the bypass network, stalls on hazards and holds the ID/EX register under
// backpressure. Macro OPFETCH_FWD_EN enables EX/WB bypassing; when undefined
// the stage stalls on every RAW dependency instead.
module operand_fetch_stage
    import opfetch_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int CTRL_BITS  = CTRL_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [CTRL_BITS-1:0]  in_ctrl,
    output logic [REG_ADDR_W-1:0] read_reg1,
    output logic [REG_ADDR_W-1:0] read_reg2,
    input  logic [XLEN-1:0]       read_data1,
    input  logic [XLEN-1:0]       read_data2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [XLEN-1:0]       ex_result,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_write_valid,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [CTRL_BITS-1:0]  out_ctrl,
    output logic [XLEN-1:0]       out_op1,
    output logic [XLEN-1:0]       out_op2
);

    logic [1:0][REG_ADDR_W-1:0] rs_vec;
    logic [1:0][XLEN-1:0]       rf_vec;
    logic [1:0][XLEN-1:0]       op_vec;
    logic [1:0]                 hazard;
    logic                       stall;
    logic                       accept;

    assign read_reg1 = in_rs1;
    assign read_reg2 = in_rs2;

    assign rs_vec = {in_rs2, in_rs1};
    assign rf_vec = {read_data2, read_data1};

    for (genvar g = 0; g < 2; g++) begin : g_src
        operand_bypass_mux #(
            .XLEN       (XLEN),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_mux (
            .rs             (rs_vec[g]),
            .read_data      (rf_vec[g]),
            .ex_rd          (ex_rd),
            .ex_reg_write   (ex_reg_write),
            .ex_mem_read    (ex_mem_read),
            .ex_result      (ex_result),
            .wb_rd          (wb_rd),
            .wb_write_valid (wb_write_valid),
            .wb_data        (wb_data),
            .operand        (op_vec[g]),
            .hazard         (hazard[g])
        );
    end

    assign stall    = in_valid && (|hazard);
    assign in_ready = !flush && !stall && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // ID/EX register: flush kills, backpressure holds, accept loads, else bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_rd    <= '0;
            out_ctrl  <= '0;
            out_op1   <= '0;
            out_op2   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_valid && !out_ready) begin
            out_valid <= out_valid;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_rd    <= in_rd;
            out_ctrl  <= in_ctrl;
            out_op1   <= op_vec[0];
            out_op2   <= op_vec[1];
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
